// File: rtl/raminfr_fifo_ctrl.sv
// Pointer, occupancy and handshake controller for a 32x4 dual-port RAM,
// forming a single-clock FIFO with one-cycle read latency.
module raminfr_fifo_ctrl #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned AFULL_TH = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    output logic [ADDR_W-1:0] ram_dpra,
    input  logic [DATA_W-1:0] ram_dpo
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Flags decode the registered occupancy only
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == CNT_W'(0));
    assign almost_full = (count >= CNT_W'(AFULL_TH));

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // RAM drive; write strobe suppressed while reset is held
    assign ram_we   = wr_acc & ~rst;
    assign ram_a    = wr_ptr;
    assign ram_di   = wr_data;
    assign ram_dpra = rd_ptr;
    assign rd_data  = ram_dpo;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            rd_valid <= rd_acc;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_raminfr_fifo_ctrl.sv
// Bench for raminfr_fifo_ctrl: behavioural RAM plus a queue-based FIFO model,
// driven by directed scenarios followed by a randomized phase.
module tb_raminfr_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       rd_en = 1'b0;
    logic       full, almost_full, rd_valid, empty, overflow, underflow;
    logic [3:0] rd_data;
    logic [5:0] count;
    logic       ram_we;
    logic [4:0] ram_a, ram_dpra;
    logic [3:0] ram_di, ram_dpo;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] q[$];
    int         wr_n = 0;
    int         rd_n = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] m_data = 4'h0;

    always #5 clk = ~clk;

    raminfr_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
        .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
    );

    // 32x4 RAM: synchronous write, registered read address
    logic [3:0] mem [32];
    logic [4:0] dpra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
        dpra_q <= ram_dpra;
    end
    assign ram_dpo = mem[dpra_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, then advance the model on the edge
    task automatic cyc(input logic we, input logic [3:0] wd, input logic re, input logic rs);
        int mcnt;
        logic wacc, racc;
        wr_en = we; wr_data = wd; rd_en = re; rst = rs;
        #4;
        mcnt = q.size();
        chk("count",       32'(count),       32'(mcnt));
        chk("empty",       32'(empty),       32'(mcnt == 0));
        chk("full",        32'(full),        32'(mcnt == 32));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= 28));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("underflow",   32'(underflow),   32'(m_unf));
        chk("rd_valid",    32'(rd_valid),    32'(m_valid));
        if (m_valid) chk("rd_data", 32'(rd_data), 32'(m_data));
        chk("ram_we",   32'(ram_we),   32'(we && mcnt < 32 && !rs));
        chk("ram_a",    32'(ram_a),    32'(wr_n % 32));
        chk("ram_dpra", 32'(ram_dpra), 32'(rd_n % 32));
        chk("ram_di",   32'(ram_di),   32'(wd));
        @(posedge clk);
        if (rs) begin
            q.delete();
            wr_n = 0; rd_n = 0;
            m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
        end else begin
            wacc = we && (mcnt < 32);
            racc = re && (mcnt > 0);
            if (we && mcnt == 32) m_ovf = 1'b1;
            if (re && mcnt == 0)  m_unf = 1'b1;
            m_valid = racc;
            if (racc) begin m_data = q.pop_front(); rd_n++; end
            if (wacc) begin q.push_back(wd); wr_n++; end
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Unchecked first reset edge brings the DUT out of X
        @(posedge clk); #1;

        // Reset values, then write 1,2,3; idle; read three back
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc(1, 4'(i), 0, 0);
        cyc(0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);
        cyc(0, 4'h0, 0, 0);

        // Fill to 32, overflow attempt, drain all
        for (int i = 0; i < 32; i++) cyc(1, 4'(i), 0, 0);
        cyc(1, 4'h5, 0, 0);
        cyc(0, 4'h0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);

        // Steady state at 16 with simultaneous traffic across pointer wrap
        for (int i = 0; i < 16; i++) cyc(1, 4'(i), 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 4'(i + 16), 1, 0);
        for (int i = 0; i < 16; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);

        // Read while empty with a same-cycle write of 0xA
        cyc(0, 4'h0, 0, 1);
        cyc(1, 4'hA, 1, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);

        // Full with simultaneous read and write: only the read is accepted
        cyc(0, 4'h0, 0, 1);
        for (int i = 0; i < 32; i++) cyc(1, 4'(i * 3), 0, 0);
        cyc(1, 4'hF, 1, 0);
        cyc(0, 4'h0, 0, 0);
        for (int i = 0; i < 31; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);

        // Reset mid-stream at count 10 with a read in flight
        for (int i = 0; i < 10; i++) cyc(1, 4'(i + 7), 0, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 1, 1);
        cyc(1, 4'h6, 0, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic we, re, rs;
            int bias;
            bias = (i / 100) % 3;
            we = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5)));
            re = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5)));
            rs = ($urandom_range(0, 199) == 0);
            cyc(we, 4'($urandom), re, rs);
        end
        cyc(0, 4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raminfr_fifo_ctrl.md
Name: raminfr_fifo_ctrl

Overview:
- Synchronous FIFO controller that owns the pointers, flags and handshake for the team's 32x4 dual-port RAM.
- Drives the RAM write port (we, a, di) and the read address (dpra), and consumes the RAM read-port data (dpo).
- Sits between a producer and a consumer; together with the RAM it forms a 32-entry single-clock FIFO.

Parameters:
- DATA_W, 4, data width; matches the RAM word width.
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W = 32.
- AFULL_TH, 28, almost_full asserts when count >= AFULL_TH.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  producer write request.
- wr_data  input  DATA_W  producer write data.
- full  output  1  FIFO holds DEPTH entries.
- almost_full  output  1  count >= AFULL_TH.
- rd_en  input  1  consumer read request.
- rd_data  output  DATA_W  read data; meaningful only while rd_valid=1.
- rd_valid  output  1  rd_data holds the word popped on the previous cycle.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- ram_we  output  1  to RAM we.
- ram_a  output  ADDR_W  to RAM a (write address).
- ram_di  output  DATA_W  to RAM di.
- ram_dpra  output  ADDR_W  to RAM dpra (read address).
- ram_dpo  input  DATA_W  from RAM dpo.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Acceptance rules:
  - Write accepted (wr_acc) iff wr_en & ~full.
  - Read accepted (rd_acc) iff rd_en & ~empty.
  - Flags are evaluated from the registered state before the edge. No write-through when full and no read-through when empty, even if the opposite operation occurs in the same cycle.
- Combinational RAM drive:
  - ram_we = wr_acc.
  - ram_a = wr_ptr.
  - ram_di = wr_data.
  - ram_dpra = rd_ptr.
- Read latency: exactly 1 cycle.
  - The RAM registers dpra on the edge that accepts the read.
  - rd_valid is registered; it is 1 in the cycle after rd_acc and 0 otherwise.
  - rd_data = ram_dpo (pass-through). It is stable for that cycle because the RAM holds its registered read address.
  - Back-to-back reads give rd_valid=1 on consecutive cycles with successive words.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W bits and increment by 1 on their respective accept.
  - Natural wrap: 31 -> 0.
- Count:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
  - Never exceeds DEPTH and never goes below 0.
- Flags:
  - full = (count == DEPTH); empty = (count == 0); almost_full = (count >= AFULL_TH).
  - All flags are derived from the registered count. They update in the cycle after the causing edge.
- Sticky errors:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both clear only on rst.
- Simultaneous read and write while not empty and not full: both accepted, count unchanged.
  - If wr_ptr == rd_ptr cannot occur in this case, because that equality implies empty or full.
- Reset values (first edge with rst=1, including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0.
  - While rst=1, ram_we=0.
  - RAM contents are not cleared but become unreachable.
  - A read accepted on the edge before reset does not produce rd_valid after reset.

Test Plan:
- Reset, then write 0x1,0x2,0x3 on 3 consecutive cycles; idle 1; rd_en for 3 cycles -> rd_valid=1 on cycles +1..+3 with rd_data 0x1,0x2,0x3; count 3->0; empty=1 afterward.
- Write 32 words 0x0..0xF,0x0..0xF -> full=1 at count=32, almost_full=1 from count=28. A 33rd wr_en -> ram_we=0, count stays 32, overflow=1 and remains set. Read all 32 -> data order preserved.
- Fill to 16, then 40 cycles of simultaneous wr_en/rd_en with an incrementing pattern -> count stays 16, pointers wrap 31->0, read data matches write order exactly.
- From empty: rd_en=1 -> rd_valid stays 0, underflow=1. Same cycle, wr_en with 0xA -> count=1; next-cycle read returns 0xA.
- Full FIFO with rd_en & wr_en together -> read accepted, write rejected, count=31, overflow=1.
- Assert rst mid-stream at count=10 with rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, sticky flags cleared. A write then read after reset returns the new data.
